res_drain: RTL and testbench

Result drain stage on the downstream side of the 10-lane result accumulator. It accepts one completed 10×32-bit accumulated vector per handshake and serializes it as one requantized word per cycle. Each word is arithmetic-shifted, then saturated to signed 8-bit. On the final beat it reports the argmax lane index. It sits between the accumulator's valid/ready output and the output stream/DMA interface.

---
 rtl/conv_pkg.sv | 34 +++
 rtl/lib_sat_shift.sv | 30 +++
 rtl/res_drain.sv | 115 +++++++++++
 tb/tb_res_drain.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, state type and requantization helper for the result drain.
//   N_LANE    lanes per accumulated vector
//   ACC_W     accumulated word width (signed)
//   OUT_W     requantized output width (signed)
//   REQ_SHIFT arithmetic right shift applied before saturation
package conv_pkg;

  localparam int unsigned N_LANE    = 10;
  localparam int unsigned ACC_W     = 32;
  localparam int unsigned OUT_W     = 8;
  localparam int unsigned REQ_SHIFT = 8;

  typedef enum logic {
    IDLE,
    SEND
  } drain_state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (OUT_W - 1)));

  // Arithmetic shift (truncates toward -inf) followed by a clamp to OUT_W signed.
  function automatic logic [OUT_W-1:0] sat_shift(input logic signed [ACC_W-1:0] v,
                                                 input int unsigned shift);
    logic signed [ACC_W-1:0] s;
    s = v >>> shift;
    if (s > SAT_MAX) begin
      return SAT_MAX[OUT_W-1:0];
    end else if (s < SAT_MIN) begin
      return SAT_MIN[OUT_W-1:0];
    end
    return s[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/lib_sat_shift.sv
// lib_sat_shift: combinational arithmetic right shift followed by signed saturation.
//   i_val  DW-bit signed input
//   o_val  OW-bit signed result, clamped to [-2^(OW-1), 2^(OW-1)-1]
module lib_sat_shift #(
  parameter int unsigned DW    = 32,
  parameter int unsigned OW    = 8,
  parameter int unsigned SHIFT = 8
) (
  input  logic signed [DW-1:0] i_val,
  output logic        [OW-1:0] o_val
);

  localparam logic signed [DW-1:0] SAT_MAX = DW'((1 << (OW - 1)) - 1);
  localparam logic signed [DW-1:0] SAT_MIN = DW'(-(1 << (OW - 1)));

  logic signed [DW-1:0] w_sh;

  // Sign-extending shift: no rounding, so negative values truncate toward -inf.
  assign w_sh = i_val >>> SHIFT;

  always_comb begin
    o_val = w_sh[OW-1:0];
    if (w_sh > SAT_MAX) begin
      o_val = SAT_MAX[OW-1:0];
    end else if (w_sh < SAT_MIN) begin
      o_val = SAT_MIN[OW-1:0];
    end
  end

endmodule

// File: rtl/res_drain.sv
// res_drain: captures one N-lane accumulated vector per handshake and streams it out one
// requantized lane per beat, reporting the argmax lane on the last beat.
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_pre_valid/o_pre_ready   upstream vector handshake, i_res sampled on pre_fire
//   o_post_valid/i_post_ready downstream beat handshake
//   o_data                    sat(buf[idx] >>> SHIFT)
//   o_idx, o_last             current lane index, high on lane N-1
//   o_class                   argmax lane index, valid with o_last
module res_drain
  import conv_pkg::*;
#(
  parameter int unsigned N     = N_LANE,
  parameter int unsigned DW    = ACC_W,
  parameter int unsigned OW    = OUT_W,
  parameter int unsigned SHIFT = REQ_SHIFT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pre_valid,
  output logic                 o_pre_ready,
  input  logic signed [DW-1:0] i_res [N-1:0],
  output logic                 o_post_valid,
  input  logic                 i_post_ready,
  output logic        [OW-1:0] o_data,
  output logic        [3:0]    o_idx,
  output logic                 o_last,
  output logic        [3:0]    o_class
);

  localparam logic [3:0] LAST_IDX = 4'(N - 1);

  drain_state_t         r_state;
  logic signed [DW-1:0] r_buf [N-1:0];
  logic        [3:0]    r_idx;
  logic signed [DW-1:0] r_runmax;
  logic        [3:0]    r_runidx;

  logic                 w_send;
  logic                 w_last;
  logic                 w_pre_fire;
  logic                 w_post_fire;
  logic signed [DW-1:0] w_cur;
  logic        [OW-1:0] w_sat;

  // All outputs are forced low while reset is held, even before the state register clears.
  assign w_send      = (r_state == SEND) && !i_rst;
  assign w_last      = w_send && (r_idx == LAST_IDX);
  // Ready depends only on state and downstream ready, never on i_pre_valid.
  assign o_pre_ready = !i_rst && ((r_state == IDLE) || (w_last && i_post_ready));
  assign w_pre_fire  = i_pre_valid && o_pre_ready;
  assign w_post_fire = w_send && i_post_ready;
  assign w_cur       = r_buf[r_idx];

  lib_sat_shift #(
    .DW   (DW),
    .OW   (OW),
    .SHIFT(SHIFT)
  ) u_sat_shift (
    .i_val(w_cur),
    .o_val(w_sat)
  );

  assign o_post_valid = w_send;
  assign o_data       = w_send ? w_sat : '0;
  assign o_idx        = w_send ? r_idx : '0;
  assign o_last       = w_last;
  // The last lane is folded in combinationally so the class is ready on the final beat.
  assign o_class      = !w_last ? 4'd0 : (r_buf[N-1] > r_runmax) ? LAST_IDX : r_runidx;

  always_ff @(posedge i_clk) begin
    if (w_pre_fire) begin
      r_buf <= i_res;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_runmax <= '0;
      r_runidx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pre_fire) begin
            r_state <= SEND;
            r_idx   <= '0;
          end
        end
        SEND: begin
          if (w_post_fire) begin
            // Beat 0 restarts the search; later beats update only on strictly greater.
            if (r_idx == 4'd0) begin
              r_runmax <= w_cur;
              r_runidx <= 4'd0;
            end else if (w_cur > r_runmax) begin
              r_runmax <= w_cur;
              r_runidx <= r_idx;
            end
            if (r_idx == LAST_IDX) begin
              r_idx <= '0;
              if (!w_pre_fire) begin
                r_state <= IDLE;
              end
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_res_drain.sv
module tb_res_drain;

  logic               i_clk;
  logic               i_rst;
  logic               i_pre_valid;
  logic               o_pre_ready;
  logic signed [31:0] i_res [9:0];
  logic               o_post_valid;
  logic               i_post_ready;
  logic        [7:0]  o_data;
  logic        [3:0]  o_idx;
  logic               o_last;
  logic        [3:0]  o_class;

  int n_pass;
  int n_total;

  res_drain dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_pre_valid (i_pre_valid),
    .o_pre_ready (o_pre_ready),
    .i_res       (i_res),
    .o_post_valid(o_post_valid),
    .i_post_ready(i_post_ready),
    .o_data      (o_data),
    .o_idx       (o_idx),
    .o_last      (o_last),
    .o_class     (o_class)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Lane k = k*256, so each beat's data equals its index and the class is 9.
  task automatic set_ramp;
    for (int k = 0; k < 10; k++) i_res[k] = k * 256;
  endtask

  // Lane 5 = 0x1000 (data 16), others 0x100 (data 1): class 5.
  task automatic set_peak5;
    for (int k = 0; k < 10; k++) i_res[k] = 32'h100;
    i_res[5] = 32'h1000;
  endtask

  task automatic test_reset;
    i_rst        = 1'b1;
    i_pre_valid  = 1'b1;
    i_post_ready = 1'b1;
    set_ramp();
    tick();
    tick();
    n_total++; if (o_pre_ready !== 1'b0) $display("FAIL rst_pre_ready got %b want 0", o_pre_ready); else n_pass++;
    n_total++; if (o_post_valid !== 1'b0) $display("FAIL rst_post_valid got %b want 0", o_post_valid); else n_pass++;
    n_total++; if (o_data !== 8'd0) $display("FAIL rst_data got %0h want 0", o_data); else n_pass++;
    n_total++; if (o_idx !== 4'd0) $display("FAIL rst_idx got %0d want 0", o_idx); else n_pass++;
    n_total++; if (o_last !== 1'b0) $display("FAIL rst_last got %b want 0", o_last); else n_pass++;
    n_total++; if (o_class !== 4'd0) $display("FAIL rst_class got %0d want 0", o_class); else n_pass++;
    i_rst       = 1'b0;
    i_pre_valid = 1'b0;
    #1;
    n_total++; if (o_pre_ready !== 1'b1) $display("FAIL post_rst_ready got %b want 1", o_pre_ready); else n_pass++;
    n_total++; if (o_post_valid !== 1'b0) $display("FAIL post_rst_valid got %b want 0", o_post_valid); else n_pass++;
    tick();
  endtask

  task automatic test_single;
    set_ramp();
    i_pre_valid  = 1'b1;
    i_post_ready = 1'b1;
    #1;
    n_total++; if (o_pre_ready !== 1'b1) $display("FAIL single_idle_ready got %b want 1", o_pre_ready); else n_pass++;
    tick();
    i_pre_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      n_total++; if (o_post_valid !== 1'b1) $display("FAIL single_valid k=%0d got %b want 1", k, o_post_valid); else n_pass++;
      n_total++; if (o_idx !== 4'(k)) $display("FAIL single_idx got %0d want %0d", o_idx, k); else n_pass++;
      n_total++; if (o_data !== 8'(k)) $display("FAIL single_data k=%0d got %0d want %0d", k, o_data, k); else n_pass++;
      n_total++; if (o_last !== (k == 9)) $display("FAIL single_last k=%0d got %b want %b", k, o_last, (k == 9)); else n_pass++;
      n_total++; if (o_pre_ready !== (k == 9)) $display("FAIL single_pre_ready k=%0d got %b want %b", k, o_pre_ready, (k == 9)); else n_pass++;
      if (k == 9) begin
        n_total++; if (o_class !== 4'd9) $display("FAIL single_class got %0d want 9", o_class); else n_pass++;
      end
      tick();
    end
    #1;
    n_total++; if (o_post_valid !== 1'b0) $display("FAIL single_end_valid got %b want 0", o_post_valid); else n_pass++;
    tick();
  endtask

  task automatic test_saturation;
    logic [7:0] exp_d [10];
    for (int k = 0; k < 10; k++) begin
      i_res[k] = 32'd0;
      exp_d[k] = 8'h00;
    end
    i_res[0] = 32'h7FFF_FFFF; exp_d[0] = 8'h7F;
    i_res[1] = 32'h8000_0000; exp_d[1] = 8'h80;
    i_res[2] = 32'h0000_7F80; exp_d[2] = 8'h7F;
    i_res[3] = 32'hFFFF_FF7F; exp_d[3] = 8'hFF;
    i_pre_valid  = 1'b1;
    i_post_ready = 1'b1;
    tick();
    i_pre_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      n_total++; if (o_data !== exp_d[k]) $display("FAIL sat_data k=%0d got %0h want %0h", k, o_data, exp_d[k]); else n_pass++;
      if (k == 9) begin
        n_total++; if (o_class !== 4'd0) $display("FAIL sat_class got %0d want 0", o_class); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_ties;
    for (int k = 0; k < 10; k++) i_res[k] = -5;
    i_res[3] = 1000;
    i_res[7] = 1000;
    i_pre_valid  = 1'b1;
    i_post_ready = 1'b1;
    tick();
    i_pre_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      // 1000 >>> 8 = 3; -5 >>> 8 = -1.
      n_total++; if (o_data !== ((k == 3 || k == 7) ? 8'h03 : 8'hFF)) $display("FAIL ties_data k=%0d got %0h", k, o_data); else n_pass++;
      if (k == 9) begin
        n_total++; if (o_class !== 4'd3) $display("FAIL ties_class got %0d want 3", o_class); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    // Vector A: strictly increasing large lanes, all saturate, class 9.
    for (int k = 0; k < 10; k++) i_res[k] = (k + 1) << 16;
    i_pre_valid  = 1'b1;
    i_post_ready = 1'b1;
    tick();
    set_peak5();
    for (int k = 0; k < 10; k++) begin
      #1;
      n_total++; if (o_idx !== 4'(k)) $display("FAIL b2b_a_idx got %0d want %0d", o_idx, k); else n_pass++;
      n_total++; if (o_data !== 8'h7F) $display("FAIL b2b_a_data k=%0d got %0h want 7f", k, o_data); else n_pass++;
      n_total++; if (o_pre_ready !== (k == 9)) $display("FAIL b2b_a_ready k=%0d got %b want %b", k, o_pre_ready, (k == 9)); else n_pass++;
      if (k == 9) begin
        n_total++; if (o_class !== 4'd9) $display("FAIL b2b_a_class got %0d want 9", o_class); else n_pass++;
      end
      tick();
    end
    i_pre_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      n_total++; if (o_post_valid !== 1'b1) $display("FAIL b2b_b_valid k=%0d got %b want 1", k, o_post_valid); else n_pass++;
      n_total++; if (o_idx !== 4'(k)) $display("FAIL b2b_b_idx got %0d want %0d", o_idx, k); else n_pass++;
      n_total++; if (o_data !== ((k == 5) ? 8'd16 : 8'd1)) $display("FAIL b2b_b_data k=%0d got %0d", k, o_data); else n_pass++;
      if (k == 9) begin
        n_total++; if (o_class !== 4'd5) $display("FAIL b2b_b_class got %0d want 5", o_class); else n_pass++;
      end
      tick();
    end
    #1;
    n_total++; if (o_post_valid !== 1'b0) $display("FAIL b2b_end_valid got %b want 0", o_post_valid); else n_pass++;
    tick();
  endtask

  task automatic test_backpressure;
    set_ramp();
    i_pre_valid  = 1'b1;
    i_post_ready = 1'b1;
    tick();
    i_pre_valid = 1'b0;
    // Ready pattern 0,1,0,1,...: each beat is shown twice, 20 cycles in total.
    for (int c = 0; c < 20; c++) begin
      i_post_ready = c[0];
      i_pre_valid  = (c == 18);
      #1;
      n_total++; if (o_post_valid !== 1'b1) $display("FAIL bp_valid c=%0d got %b want 1", c, o_post_valid); else n_pass++;
      n_total++; if (o_idx !== 4'(c / 2)) $display("FAIL bp_idx c=%0d got %0d want %0d", c, o_idx, c / 2); else n_pass++;
      n_total++; if (o_data !== 8'(c / 2)) $display("FAIL bp_data c=%0d got %0d want %0d", c, o_data, c / 2); else n_pass++;
      if (c == 18) begin
        n_total++; if (o_pre_ready !== 1'b0) $display("FAIL bp_last_stall_ready got %b want 0", o_pre_ready); else n_pass++;
      end
      i_pre_valid = 1'b0;
      tick();
    end
    #1;
    n_total++; if (o_post_valid !== 1'b0) $display("FAIL bp_end_valid got %b want 0", o_post_valid); else n_pass++;
    tick();
  endtask

  task automatic test_mid_reset;
    set_ramp();
    i_pre_valid  = 1'b1;
    i_post_ready = 1'b1;
    tick();
    i_pre_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    #1;
    n_total++; if (o_idx !== 4'd4) $display("FAIL mrst_pre_idx got %0d want 4", o_idx); else n_pass++;
    tick();
    i_rst = 1'b1;
    tick();
    n_total++; if (o_post_valid !== 1'b0) $display("FAIL mrst_valid got %b want 0", o_post_valid); else n_pass++;
    n_total++; if (o_data !== 8'd0) $display("FAIL mrst_data got %0h want 0", o_data); else n_pass++;
    n_total++; if (o_idx !== 4'd0) $display("FAIL mrst_idx got %0d want 0", o_idx); else n_pass++;
    n_total++; if (o_pre_ready !== 1'b0) $display("FAIL mrst_ready got %b want 0", o_pre_ready); else n_pass++;
    i_rst = 1'b0;
    #1;
    n_total++; if (o_pre_ready !== 1'b1) $display("FAIL mrst_release_ready got %b want 1", o_pre_ready); else n_pass++;
    n_total++; if (o_post_valid !== 1'b0) $display("FAIL mrst_release_valid got %b want 0", o_post_valid); else n_pass++;
    tick();
    set_peak5();
    i_pre_valid = 1'b1;
    tick();
    i_pre_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      n_total++; if (o_idx !== 4'(k)) $display("FAIL mrst_new_idx got %0d want %0d", o_idx, k); else n_pass++;
      n_total++; if (o_data !== ((k == 5) ? 8'd16 : 8'd1)) $display("FAIL mrst_new_data k=%0d got %0d", k, o_data); else n_pass++;
      if (k == 9) begin
        n_total++; if (o_class !== 4'd5) $display("FAIL mrst_new_class got %0d want 5", o_class); else n_pass++;
      end
      tick();
    end
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    i_rst        = 1'b1;
    i_pre_valid  = 1'b0;
    i_post_ready = 1'b0;
    for (int k = 0; k < 10; k++) i_res[k] = 32'd0;
    test_reset();
    test_single();
    test_saturation();
    test_ties();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
